// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel control: key synchronizers, debouncers, control FSM and display hold.
// Optional lap-freeze feature is enabled by defining STOPWATCH_CTRL_LAP_EN.

module stopwatch_ctrl_debounce #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;

    // Two-flop synchronizer, stability counter and single-cycle press pulse on a debounced fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= 2'b11;
            level_r <= 1'b1;
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], key_n};
            press_r <= 1'b0;
            if (sync_r[1] == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                level_r <= ~level_r;
                cnt_r   <= '0;
                press_r <= level_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign press = press_r;
endmodule

module stopwatch_ctrl_checker (
    input logic clk,
    input logic rst_n,
    input logic run,
    input logic clear,
    input logic lap_active
);
    a_clear_single: assert property (@(posedge clk) disable iff (!rst_n) clear |=> !clear);
    a_clear_stopped: assert property (@(posedge clk) disable iff (!rst_n) clear |-> !run);
    a_lap_runs: assert property (@(posedge clk) disable iff (!rst_n) lap_active |-> run);
endmodule

module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       KEY_START_N,
    input  logic       KEY_LAP_N,
    input  logic [3:0] MIN,
    input  logic [3:0] TENSEC,
    input  logic [3:0] SEC,
    input  logic [3:0] DECISEC,
    input  logic [3:0] CENTISEC,
    output logic       RUN,
    output logic       CLEAR,
    output logic       LAP_ACTIVE,
    output logic [3:0] D_MIN,
    output logic [3:0] D_TENSEC,
    output logic [3:0] D_SEC,
    output logic [3:0] D_DECISEC,
    output logic [3:0] D_CENTISEC
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        start_ev_s;
    logic        lap_ev_s;
    logic        clear_s;
    logic        capture_s;
    logic [19:0] live_s;
    logic [19:0] disp_next_s;
    logic [19:0] disp_r;
    logic        run_r;
    logic        clear_r;
    logic        lap_active_r;

    assign live_s = {MIN, TENSEC, SEC, DECISEC, CENTISEC};

    stopwatch_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk   (CLK),
        .rst_n (RESET_N),
        .key_n (KEY_START_N),
        .press (start_ev_s)
    );

    stopwatch_ctrl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk   (CLK),
        .rst_n (RESET_N),
        .key_n (KEY_LAP_N),
        .press (lap_ev_s)
    );

    // Next-state decode; a start event always takes priority over a lap event
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ev_s) begin
                    next_state_s = ST_RUNNING;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (start_ev_s) begin
                    next_state_s = ST_STOPPED;
                end else if (lap_ev_s) begin
`ifdef STOPWATCH_CTRL_LAP_EN
                    next_state_s = ST_LAP;
                    capture_s    = 1'b1;
`else
                    next_state_s = ST_RUNNING;
`endif
                end else begin
                    next_state_s = ST_RUNNING;
                end
            end
            ST_LAP: begin
`ifdef STOPWATCH_CTRL_LAP_EN
                if (start_ev_s) begin
                    next_state_s = ST_STOPPED;
                end else if (lap_ev_s) begin
                    next_state_s = ST_RUNNING;
                end else begin
                    next_state_s = ST_LAP;
                end
`else
                next_state_s = ST_IDLE;
`endif
            end
            ST_STOPPED: begin
                if (start_ev_s) begin
                    next_state_s = ST_RUNNING;
                end else if (lap_ev_s) begin
                    next_state_s = ST_IDLE;
                    clear_s      = 1'b1;
                end else begin
                    next_state_s = ST_STOPPED;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered control outputs derived from the next state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            run_r        <= 1'b0;
            clear_r      <= 1'b0;
            lap_active_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            run_r        <= (next_state_s == ST_RUNNING) || (next_state_s == ST_LAP);
            clear_r      <= clear_s;
`ifdef STOPWATCH_CTRL_LAP_EN
            lap_active_r <= (next_state_s == ST_LAP);
`else
            lap_active_r <= 1'b0;
`endif
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    logic [19:0] lap_r;

    // Lap capture register, loaded with the live digits on the edge that enters LAP
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lap_r <= 20'd0;
        end else if (capture_s) begin
            lap_r <= live_s;
        end else begin
            lap_r <= lap_r;
        end
    end

    // On entry the live value equals the value being captured, so live is shown that edge
    assign disp_next_s = ((state_r == ST_LAP) && (next_state_s == ST_LAP)) ? lap_r : live_s;
`else
    assign disp_next_s = live_s;
`endif

    // Display register feeding the seven-segment decoders
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            disp_r <= 20'd0;
        end else begin
            disp_r <= disp_next_s;
        end
    end

    assign RUN        = run_r;
    assign CLEAR      = clear_r;
    assign LAP_ACTIVE = lap_active_r;
    assign D_MIN      = disp_r[19:16];
    assign D_TENSEC   = disp_r[15:12];
    assign D_SEC      = disp_r[11:8];
    assign D_DECISEC  = disp_r[7:4];
    assign D_CENTISEC = disp_r[3:0];

    stopwatch_ctrl_checker u_checker (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .run        (run_r),
        .clear      (clear_r),
        .lap_active (lap_active_r)
    );
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl with a behavioural model and directed literal checks.
module tb_stopwatch_ctrl;
    localparam int DB = 4;

    logic CLK = 1'b0;
    logic RESET_N = 1'b1;
    logic KEY_START_N = 1'b1;
    logic KEY_LAP_N = 1'b1;
    logic [3:0] MIN = 4'd0, TENSEC = 4'd0, SEC = 4'd0, DECISEC = 4'd0, CENTISEC = 4'd0;
    logic RUN, CLEAR, LAP_ACTIVE;
    logic [3:0] D_MIN, D_TENSEC, D_SEC, D_DECISEC, D_CENTISEC;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .KEY_START_N(KEY_START_N), .KEY_LAP_N(KEY_LAP_N),
        .MIN(MIN), .TENSEC(TENSEC), .SEC(SEC), .DECISEC(DECISEC), .CENTISEC(CENTISEC),
        .RUN(RUN), .CLEAR(CLEAR), .LAP_ACTIVE(LAP_ACTIVE),
        .D_MIN(D_MIN), .D_TENSEC(D_TENSEC), .D_SEC(D_SEC), .D_DECISEC(D_DECISEC),
        .D_CENTISEC(D_CENTISEC)
    );

    wire [19:0] d_all = {D_MIN, D_TENSEC, D_SEC, D_DECISEC, D_CENTISEC};

    // model: mode 0 idle, 1 running, 2 lap, 3 stopped
    int          m_mode = 0;
    logic [19:0] m_lap = 20'd0;
    logic [19:0] exp_d = 20'd0;
    bit          exp_run = 1'b0, exp_clr = 1'b0, exp_lapa = 1'b0;
    bit          s1[2] = '{1'b1, 1'b1};
    bit          s2[2] = '{1'b1, 1'b1};
    bit          lvl[2] = '{1'b1, 1'b1};
    int          run_len[2] = '{0, 0};
    bit          ev[2] = '{1'b0, 1'b0};
    bit          nev[2];
    bit          raw[2];
    bit          smp;
    logic [19:0] live;

    task automatic check(input string nm, input logic [19:0] act, input logic [19:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_mode = 0; m_lap = 20'd0; exp_d = 20'd0;
            exp_run = 1'b0; exp_clr = 1'b0; exp_lapa = 1'b0;
            for (int k = 0; k < 2; k++) begin
                s1[k] = 1'b1; s2[k] = 1'b1; lvl[k] = 1'b1; run_len[k] = 0; ev[k] = 1'b0;
            end
        end else begin
            live = {MIN, TENSEC, SEC, DECISEC, CENTISEC};
            exp_clr = 1'b0;
            if (ev[0]) begin
                m_mode = (m_mode == 1 || m_mode == 2) ? 3 : 1;
            end else if (ev[1]) begin
                if (m_mode == 1) begin
`ifdef STOPWATCH_CTRL_LAP_EN
                    m_mode = 2;
                    m_lap = live;
`endif
                end else if (m_mode == 2) begin
                    m_mode = 1;
                end else if (m_mode == 3) begin
                    m_mode = 0;
                    exp_clr = 1'b1;
                end
            end
            exp_run  = (m_mode == 1) || (m_mode == 2);
            exp_lapa = (m_mode == 2);
            exp_d    = (m_mode == 2) ? m_lap : live;
            raw[0] = KEY_START_N;
            raw[1] = KEY_LAP_N;
            for (int k = 0; k < 2; k++) begin
                smp = s2[k];
                s2[k] = s1[k];
                s1[k] = raw[k];
                nev[k] = 1'b0;
                if (smp != lvl[k]) begin
                    run_len[k]++;
                    if (run_len[k] == DB) begin
                        lvl[k] = smp;
                        run_len[k] = 0;
                        nev[k] = !smp;
                    end
                end else begin
                    run_len[k] = 0;
                end
            end
            ev = nev;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            check("run", RUN, exp_run);
            check("clear", CLEAR, exp_clr);
            check("lap_active", LAP_ACTIVE, exp_lapa);
            check("digits", d_all, exp_d);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_run"}, RUN, 20'd0);
        check({nm, "_clear"}, CLEAR, 20'd0);
        check({nm, "_lapa"}, LAP_ACTIVE, 20'd0);
        check({nm, "_digits"}, d_all, 20'd0);
    endtask

    task automatic set_digits(input logic [19:0] v);
        {MIN, TENSEC, SEC, DECISEC, CENTISEC} = v;
    endtask

    bit kl[2];
    int hold[2];

    initial begin
        #3 RESET_N = 1'b0;
        #1 check_reset_outputs("reset");
        chk_en = 1'b1;
        step(2);
        RESET_N = 1'b1;
        set_digits(20'h12345);
        step(2);

        // start press: RUN rises on edge DB+3 = 7
        KEY_START_N = 1'b0;
        step(6); check("run_edge6", RUN, 20'd0);
        step(1); check("run_edge7", RUN, 20'd1); check("model_run_edge7", exp_run, 20'd1);
        step(5); KEY_START_N = 1'b1; step(DB + 4);

        // short glitch leaves everything alone
        KEY_START_N = 1'b0; step(3); KEY_START_N = 1'b1; step(10);
        check("glitch_run", RUN, 20'd1);
        check("glitch_cnt", dut.u_db_start.cnt_r, 20'd0);

        // lap press while running
        KEY_LAP_N = 1'b0; step(7);
`ifdef STOPWATCH_CTRL_LAP_EN
        check("lap_enter_lapa", LAP_ACTIVE, 20'd1);
        check("lap_enter_d", d_all, 20'h12345);
        set_digits(20'h98765); step(3);
        check("lap_hold_d", d_all, 20'h12345);
        check("lap_hold_run", RUN, 20'd1);
        KEY_LAP_N = 1'b1; step(DB + 4);
        KEY_LAP_N = 1'b0; step(7);
        check("lap_exit_lapa", LAP_ACTIVE, 20'd0);
        step(1); check("lap_exit_d", d_all, 20'h98765);
`else
        check("lap_ignored_lapa", LAP_ACTIVE, 20'd0);
        check("lap_ignored_run", RUN, 20'd1);
        set_digits(20'h98765); step(1);
        check("lap_ignored_d", d_all, 20'h98765);
`endif
        KEY_LAP_N = 1'b1; step(DB + 4);

        // stop, then lap clears exactly once
        KEY_START_N = 1'b0; step(7); check("stop_run", RUN, 20'd0);
        KEY_START_N = 1'b1; step(DB + 4);
        KEY_LAP_N = 1'b0; step(6); check("clear_before", CLEAR, 20'd0);
        step(1); check("clear_pulse", CLEAR, 20'd1); check("clear_run", RUN, 20'd0);
        step(1); check("clear_after", CLEAR, 20'd0);
        KEY_LAP_N = 1'b1; step(DB + 4);
        KEY_LAP_N = 1'b0; step(12);
        check("idle_lap_clear", CLEAR, 20'd0); check("idle_lap_run", RUN, 20'd0);
        KEY_LAP_N = 1'b1; step(DB + 4);

        // simultaneous start and lap from running: start wins
        KEY_START_N = 1'b0; step(7); check("sim_pre_run", RUN, 20'd1);
        KEY_START_N = 1'b1; step(DB + 4);
        KEY_START_N = 1'b0; KEY_LAP_N = 1'b0; step(7);
        check("sim_run", RUN, 20'd0); check("sim_lapa", LAP_ACTIVE, 20'd0);
        KEY_START_N = 1'b1; KEY_LAP_N = 1'b1; step(DB + 4);

        // reset while in lap with a release debounce in flight
        KEY_START_N = 1'b0; step(7); KEY_START_N = 1'b1; step(DB + 4);
        KEY_LAP_N = 1'b0; step(7); KEY_LAP_N = 1'b1; step(3);
        RESET_N = 1'b0; #1 check_reset_outputs("mid_reset");
        step(1); RESET_N = 1'b1; step(3);
        check("post_reset_run", RUN, 20'd0); check("post_reset_lapa", LAP_ACTIVE, 20'd0);

        // randomized phase
        hold[0] = 0; hold[1] = 0; kl[0] = 1'b1; kl[1] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            set_digits({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
            for (int k = 0; k < 2; k++) begin
                if (hold[k] == 0) begin
                    kl[k] = 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 12);
                end else begin
                    hold[k]--;
                end
            end
            KEY_START_N = kl[0];
            KEY_LAP_N = kl[1];
            if ($urandom_range(0, 499) == 0) begin
                #2 RESET_N = 1'b0;
                #1 check_reset_outputs("rand_reset");
                step(1);
                RESET_N = 1'b1;
            end
            step(1);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel control stage for the stopwatch, sitting directly upstream of the stopwatch counter core and in front of the seven-segment decoders. It debounces the raw start/stop and lap/clear pushbuttons and runs a four-state control FSM. The FSM drives the counter's enable and synchronous clear inputs. It also passes either the live digit values or a frozen lap capture to the display path.

## Interface
Parameters:
- DB_CYCLES, default 1000: consecutive stable samples required before a debounced key changes state; legal range 2..65535.

Ports:
- CLK  in  1  system clock (the variable clock that also drives the counter core)
- RESET_N  in  1  asynchronous, active-low reset
- KEY_START_N  in  1  raw start/stop pushbutton, asynchronous, low = pressed
- KEY_LAP_N  in  1  raw lap/clear pushbutton, asynchronous, low = pressed
- MIN, TENSEC, SEC, DECISEC, CENTISEC  in  4 each  live BCD digits from the counter core
- RUN  out  1  counter enable
- CLEAR  out  1  one-cycle synchronous clear pulse to the counter core
- LAP_ACTIVE  out  1  high while the display is frozen; drives an LED
- D_MIN, D_TENSEC, D_SEC, D_DECISEC, D_CENTISEC  out  4 each  digits to the display decoders

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer.
- Debouncer:
  - Holds a debounced level, reset value 1 (released), and a counter of width clog2(DB_CYCLES+1), reset value 0.
  - When the synchronized sample equals the debounced level, the counter clears to 0. Otherwise the counter increments.
  - On the DB_CYCLES-th consecutive differing sample, the debounced level flips and the counter clears.
- Press event: a one-cycle pulse on a debounced 1→0 transition. Releases generate no event.
- FSM states: IDLE (reset state), RUNNING, LAP, STOPPED.
  - IDLE: start → RUNNING. Lap is ignored.
  - RUNNING: start → STOPPED. Lap → LAP; the five live digits are captured into the lap register on that edge.
  - LAP: lap → RUNNING. Start → STOPPED. Leaving LAP releases the display to the live digits.
  - STOPPED: start → RUNNING. Lap → IDLE, with CLEAR high for exactly that one cycle.
- Simultaneous start and lap events in the same cycle: start wins and lap is discarded.
- RUN = 1 in RUNNING and LAP; 0 in IDLE and STOPPED. The counter keeps running while the lap display is frozen.
- LAP_ACTIVE = 1 only in LAP.
- D_* outputs are registered. In LAP they hold the lap register; in all other states they follow the live inputs.
- Reset values:
  - RUN, CLEAR, LAP_ACTIVE = 0.
  - All D_* = 0 and the lap register = 0.
  - FSM in IDLE; both debouncers at released with counters at 0; synchronizers at 1.
- Reset assertion at any time, including mid-debounce or in LAP, returns everything to the reset values immediately.
- A key held low through reset release is seen as a new press after debounce.

## Timing
- Edge 1 is the first rising edge that samples a key low; the key is then held stable.
  - The synchronizer output is low after edge 2.
  - The debounced level flips on edge DB_CYCLES+2.
  - The FSM state, RUN, LAP_ACTIVE and CLEAR update on edge DB_CYCLES+3.
- D_* follow the live inputs with 1 cycle of latency.
- When LAP is entered, the value captured is the live digits sampled on the transition edge. D_* show the captured value from that same edge onward.
- A key glitch shorter than DB_CYCLES samples produces no event and leaves the debounced level unchanged.
- One physical press produces exactly one event, regardless of hold duration.
- CLEAR is never high for more than one consecutive cycle.

## Configuration
- STOPWATCH_CTRL_LAP_EN defined:
  - Full behaviour as described above.
- STOPWATCH_CTRL_LAP_EN undefined:
  - The LAP state and lap register are removed.
  - A lap event in RUNNING is ignored.
  - LAP_ACTIVE is tied to 0.
  - D_* always follow the live inputs with 1-cycle latency.
  - The lap key still performs clear from STOPPED.

## Test plan
- Reset, then hold KEY_START_N low with DB_CYCLES=4: RUN rises on edge 7 and stays high. Release and press again: RUN falls (STOPPED).
- A 3-cycle low glitch on KEY_START_N with DB_CYCLES=4: no event; RUN, state and debouncer counter end unchanged.
- RUNNING with live digits 1,2,3,4,5, then a lap press: D_* freeze at 1,2,3,4,5 while live inputs advance and RUN stays 1. A second lap press: D_* return to the live values one cycle later.
- STOPPED, then a lap press: CLEAR is high for exactly one cycle, the state is IDLE and RUN = 0. A further lap press in IDLE produces no output change.
- Start and lap debounced in the same cycle from RUNNING: state becomes STOPPED and LAP_ACTIVE stays 0.
- RESET_N pulsed low while in LAP mid-debounce: all outputs are 0 asynchronously, and the state is IDLE on release.
